// File: rtl/ilm_pkg.sv
// Shared definitions for ILM accumulator blocks: default widths and the
// job-level state encoding.
package ilm_pkg;

    localparam int unsigned PROD_W_DEF = 17;
    localparam int unsigned ACC_W_DEF  = 24;
    localparam int unsigned LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } ilm_state_t;

endpackage

// File: rtl/ilm_sat_add.sv
// Combinational signed saturating adder: a (A_W bits) + sign-extended b (B_W
// bits), clamped to the A_W range. Requires A_W > B_W.
module ilm_sat_add #(
    parameter int unsigned A_W = 24,
    parameter int unsigned B_W = 17
) (
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic [A_W-1:0] sum,
    output logic           ovf
);

    logic [A_W:0] full;

    always_comb begin
        full = {a[A_W-1], a} + {{(A_W+1-B_W){b[B_W-1]}}, b};
        // The two top bits disagree only when the true result left the A_W range.
        ovf  = full[A_W] ^ full[A_W-1];
        if (!ovf)
            sum = full[A_W-1:0];
        else if (full[A_W])
            sum = {1'b1, {(A_W-1){1'b0}}};
        else
            sum = {1'b0, {(A_W-1){1'b1}}};
    end

endmodule

// File: rtl/ilm_dot_accum.sv
// Dot-product accumulator for ILM products: sums a programmed number of
// signed beats with saturation and presents one result per job.
module ilm_dot_accum
    import ilm_pkg::*;
#(
    parameter int unsigned PROD_W = PROD_W_DEF,
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_product,
    input  logic              in_carry,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_sat,
    output logic              out_carry,
    output logic              busy
);

    ilm_state_t        state, state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  add_sum;
    logic              add_ovf;
    logic [LEN_W-1:0]  count;
    logic [LEN_W-1:0]  last_idx;
    logic              sat_r;
    logic              carry_r;
    logic              accept;
    logic              last_beat;

    ilm_sat_add #(
        .A_W (ACC_W),
        .B_W (PROD_W)
    ) u_sat_add (
        .a   (acc),
        .b   (in_product),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    assign accept    = in_valid & in_ready;
    assign last_beat = (count == last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_beat)
                    state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            count     <= '0;
            last_idx  <= '0;
            sat_r     <= 1'b0;
            carry_r   <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
            out_carry <= 1'b0;
        end else if (state == IDLE && start) begin
            // Storing len-1 lets a zero length fold naturally into a one-beat job.
            last_idx <= (cfg_len == '0) ? '0 : cfg_len - LEN_W'(1);
            acc      <= '0;
            count    <= '0;
            sat_r    <= 1'b0;
            carry_r  <= 1'b0;
        end else if (accept) begin
            acc     <= add_sum;
            count   <= count + LEN_W'(1);
            sat_r   <= sat_r | add_ovf;
            carry_r <= carry_r | in_carry;
            if (last_beat) begin
                out_sum   <= add_sum;
                out_sat   <= sat_r | add_ovf;
                out_carry <= carry_r | in_carry;
            end
        end
    end

endmodule
